// File: rtl/csr_counter_unit_pkg.sv
// Shared types for the tiny5 performance-counter CSR unit: Zicsr funct3 encodings,
// counter CSR addresses, mcountinhibit bit positions and the RW/RS/RC update helpers.
package csr_counter_unit_pkg;

  typedef enum logic [2:0] {
    F3_PRIV   = 3'b000,
    F3_CSRRW  = 3'b001,
    F3_CSRRS  = 3'b010,
    F3_CSRRC  = 3'b011,
    F3_RSV    = 3'b100,
    F3_CSRRWI = 3'b101,
    F3_CSRRSI = 3'b110,
    F3_CSRRCI = 3'b111
  } funct3_system_t;

  typedef enum logic [11:0] {
    CSR_REG_MCOUNTINHIBIT = 12'h320,
    CSR_REG_MCYCLE        = 12'hB00,
    CSR_REG_MINSTRET      = 12'hB02,
    CSR_REG_MCYCLEH       = 12'hB80,
    CSR_REG_MINSTRETH     = 12'hB82,
    CSR_REG_CYCLE         = 12'hC00,
    CSR_REG_TIME          = 12'hC01,
    CSR_REG_INSTRET       = 12'hC02,
    CSR_REG_CYCLEH        = 12'hC80,
    CSR_REG_TIMEH         = 12'hC81,
    CSR_REG_INSTRETH      = 12'hC82
  } csr_reg_t;

  localparam int MCOUNTINHIBIT_CY = 0;
  localparam int MCOUNTINHIBIT_IR = 2;

  // S/C forms with a zero source are pure reads; RW forms always write.
  function automatic logic csr_writes(funct3_system_t op, logic src_zero);
    return (op == F3_CSRRW) || (op == F3_CSRRWI) || !src_zero;
  endfunction

  function automatic logic [31:0] csr_apply(funct3_system_t op, logic [31:0] old,
                                            logic [31:0] wd);
    logic [31:0] res;
    case (op)
      F3_CSRRW, F3_CSRRWI: res = wd;
      F3_CSRRS, F3_CSRRSI: res = old | wd;
      default:             res = old & ~wd;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/csr_counter_unit_counter.sv
// One wrapping counter with 32-bit low/high word write ports; any write wins over
// that cycle's increment and leaves the unwritten half untouched.
module csr_counter #(
  parameter int WIDTH = 64
) (
  input  logic             clk_i,
  input  logic             reset_ni,
  input  logic             inc_i,
  input  logic             wr_lo_i,
  input  logic             wr_hi_i,
  input  logic [31:0]      wdata_i,
  output logic [WIDTH-1:0] count_o
);

  logic [WIDTH-1:0] count_d;

  always_comb begin
    count_d = count_o;
    if (wr_lo_i || wr_hi_i) begin
      if (wr_lo_i) count_d[31:0] = wdata_i;
      if (wr_hi_i) count_d[WIDTH-1:32] = wdata_i[WIDTH-33:0];
    end else if (inc_i) begin
      count_d = count_o + WIDTH'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (!reset_ni) count_o <= '0;
    else           count_o <= count_d;
  end

endmodule

// File: rtl/csr_counter_unit.sv
// cycle/time/instret counter CSRs with mcountinhibit and a time prescaler; one-cycle
// registered response carrying the pre-edge value, no backpressure.
module csr_counter_unit
  import csr_counter_unit_pkg::*;
#(
  parameter int COUNTER_WIDTH = 64,
  parameter int TIME_DIV      = 1
) (
  input  logic        clk_i,
  input  logic        reset_ni,
  input  logic        csr_valid_i,
  input  logic [2:0]  csr_funct3_i,
  input  logic [11:0] csr_addr_i,
  input  logic [31:0] csr_wdata_i,
  input  logic        csr_src_zero_i,
  input  logic        instret_i,
  output logic        rsp_valid_o,
  output logic [31:0] rsp_rdata_o,
  output logic        rsp_illegal_o
);

  localparam int PRESC_W = (TIME_DIV > 1) ? $clog2(TIME_DIV) : 1;
  localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(TIME_DIV - 1);

  logic [COUNTER_WIDTH-1:0] cycle_q, time_q, instret_q;
  logic [PRESC_W-1:0]       presc_q;
  logic                     inh_cy_q, inh_ir_q;
  logic                     time_tick;

  funct3_system_t op;
  csr_reg_t       addr;
  logic [31:0]    old_val, wval;
  logic           mapped, read_only, writes, illegal, commit;

  assign op   = funct3_system_t'(csr_funct3_i);
  assign addr = csr_reg_t'(csr_addr_i);

  always_comb begin
    old_val   = '0;
    mapped    = 1'b1;
    read_only = 1'b0;
    case (addr)
      CSR_REG_CYCLE:    begin old_val = cycle_q[31:0];                 read_only = 1'b1; end
      CSR_REG_TIME:     begin old_val = time_q[31:0];                  read_only = 1'b1; end
      CSR_REG_INSTRET:  begin old_val = instret_q[31:0];               read_only = 1'b1; end
      CSR_REG_CYCLEH:   begin old_val = 32'(cycle_q[COUNTER_WIDTH-1:32]);   read_only = 1'b1; end
      CSR_REG_TIMEH:    begin old_val = 32'(time_q[COUNTER_WIDTH-1:32]);    read_only = 1'b1; end
      CSR_REG_INSTRETH: begin old_val = 32'(instret_q[COUNTER_WIDTH-1:32]); read_only = 1'b1; end
      CSR_REG_MCYCLE:    old_val = cycle_q[31:0];
      CSR_REG_MINSTRET:  old_val = instret_q[31:0];
      CSR_REG_MCYCLEH:   old_val = 32'(cycle_q[COUNTER_WIDTH-1:32]);
      CSR_REG_MINSTRETH: old_val = 32'(instret_q[COUNTER_WIDTH-1:32]);
      CSR_REG_MCOUNTINHIBIT: old_val = {29'b0, inh_ir_q, 1'b0, inh_cy_q};
      default: mapped = 1'b0;
    endcase
  end

  assign writes  = csr_writes(op, csr_src_zero_i);
  assign illegal = !mapped || (op == F3_PRIV) || (op == F3_RSV) || (read_only && writes);
  assign commit  = csr_valid_i && !illegal && writes;
  assign wval    = csr_apply(op, old_val, csr_wdata_i);

  // Inhibit bits are sampled from the register, so a write only affects later edges.
  always_ff @(posedge clk_i) begin
    if (!reset_ni) begin
      inh_cy_q <= 1'b0;
      inh_ir_q <= 1'b0;
    end else if (commit && addr == CSR_REG_MCOUNTINHIBIT) begin
      inh_cy_q <= wval[MCOUNTINHIBIT_CY];
      inh_ir_q <= wval[MCOUNTINHIBIT_IR];
    end
  end

  assign time_tick = (presc_q == PRESC_LAST);

  always_ff @(posedge clk_i) begin
    if (!reset_ni)      presc_q <= '0;
    else if (time_tick) presc_q <= '0;
    else                presc_q <= presc_q + PRESC_W'(1);
  end

  csr_counter #(.WIDTH(COUNTER_WIDTH)) u_cycle (
    .clk_i   (clk_i),
    .reset_ni(reset_ni),
    .inc_i   (!inh_cy_q),
    .wr_lo_i (commit && addr == CSR_REG_MCYCLE),
    .wr_hi_i (commit && addr == CSR_REG_MCYCLEH),
    .wdata_i (wval),
    .count_o (cycle_q)
  );

  csr_counter #(.WIDTH(COUNTER_WIDTH)) u_time (
    .clk_i   (clk_i),
    .reset_ni(reset_ni),
    .inc_i   (time_tick),
    .wr_lo_i (1'b0),
    .wr_hi_i (1'b0),
    .wdata_i (32'b0),
    .count_o (time_q)
  );

  csr_counter #(.WIDTH(COUNTER_WIDTH)) u_instret (
    .clk_i   (clk_i),
    .reset_ni(reset_ni),
    .inc_i   (instret_i && !inh_ir_q),
    .wr_lo_i (commit && addr == CSR_REG_MINSTRET),
    .wr_hi_i (commit && addr == CSR_REG_MINSTRETH),
    .wdata_i (wval),
    .count_o (instret_q)
  );

  always_ff @(posedge clk_i) begin
    if (!reset_ni) begin
      rsp_valid_o   <= 1'b0;
      rsp_rdata_o   <= '0;
      rsp_illegal_o <= 1'b0;
    end else begin
      rsp_valid_o   <= csr_valid_i;
      rsp_rdata_o   <= (csr_valid_i && !illegal) ? old_val : '0;
      rsp_illegal_o <= csr_valid_i && illegal;
    end
  end

endmodule

// File: tb/tb_csr_counter_unit.sv
// Drives a 64-bit/TIME_DIV=4 and a 40-bit/TIME_DIV=3 instance with identical stimulus;
// a reference model predicts each response into a queue that per-DUT monitors drain.
module tb_csr_counter_unit;

  logic        clk = 1'b0;
  logic        reset_ni;
  logic        csr_valid;
  logic [2:0]  f3;
  logic [11:0] addr;
  logic [31:0] wd;
  logic        srcz;
  logic        ir;

  logic        a_vld, b_vld, a_ill, b_ill;
  logic [31:0] a_dat, b_dat;

  always #5 clk = ~clk;

  csr_counter_unit #(.COUNTER_WIDTH(64), .TIME_DIV(4)) dut_a (
    .clk_i(clk), .reset_ni(reset_ni), .csr_valid_i(csr_valid), .csr_funct3_i(f3),
    .csr_addr_i(addr), .csr_wdata_i(wd), .csr_src_zero_i(srcz), .instret_i(ir),
    .rsp_valid_o(a_vld), .rsp_rdata_o(a_dat), .rsp_illegal_o(a_ill)
  );

  csr_counter_unit #(.COUNTER_WIDTH(40), .TIME_DIV(3)) dut_b (
    .clk_i(clk), .reset_ni(reset_ni), .csr_valid_i(csr_valid), .csr_funct3_i(f3),
    .csr_addr_i(addr), .csr_wdata_i(wd), .csr_src_zero_i(srcz), .instret_i(ir),
    .rsp_valid_o(b_vld), .rsp_rdata_o(b_dat), .rsp_illegal_o(b_ill)
  );

  int n_vec = 0;
  int n_err = 0;
  bit mon_on = 1'b0;

  int          w_of [2] = '{64, 40};
  int          td_of[2] = '{4, 3};
  logic [63:0] m_cyc[2], m_tim[2], m_ins[2];
  logic [31:0] m_inh[2];
  int          m_pre[2];
  logic [32:0] exp_a[$], exp_b[$];   // {rdata, illegal}

  function automatic logic [63:0] wmask(int w);
    return (w == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << w) - 64'd1);
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_cyc[k] = '0; m_tim[k] = '0; m_ins[k] = '0; m_inh[k] = '0; m_pre[k] = 0;
    end
  endtask

  // One clock edge of the architectural counters as seen by software.
  task automatic model_step(input int k);
    logic [63:0] m = wmask(w_of[k]);
    logic [31:0] old = '0, nv = '0, new_inh;
    bit mapped = 1, ro, wr, ill, wr_cy = 0, wr_ir = 0;
    bit tick = (m_pre[k] == td_of[k] - 1);
    ro = (addr[11:8] == 4'hC);
    case (addr)
      12'hC00, 12'hB00: old = m_cyc[k][31:0];
      12'hC80, 12'hB80: old = m_cyc[k][63:32];
      12'hC01:          old = m_tim[k][31:0];
      12'hC81:          old = m_tim[k][63:32];
      12'hC02, 12'hB02: old = m_ins[k][31:0];
      12'hC82, 12'hB82: old = m_ins[k][63:32];
      12'h320:          old = m_inh[k];
      default:          mapped = 0;
    endcase
    wr  = (f3 == 3'b001) || (f3 == 3'b101) || !srcz;
    ill = !mapped || f3 == 3'b000 || f3 == 3'b100 || (ro && wr);
    if (csr_valid) begin
      if (k == 0) exp_a.push_back({ill ? 32'h0 : old, ill});
      else        exp_b.push_back({ill ? 32'h0 : old, ill});
    end
    new_inh = m_inh[k];
    if (csr_valid && !ill && wr) begin
      case (f3[1:0])
        2'b01:   nv = wd;
        2'b10:   nv = old | wd;
        default: nv = old & ~wd;
      endcase
      case (addr)
        12'hB00: begin m_cyc[k] = {m_cyc[k][63:32], nv} & m; wr_cy = 1; end
        12'hB80: begin m_cyc[k] = {nv, m_cyc[k][31:0]} & m; wr_cy = 1; end
        12'hB02: begin m_ins[k] = {m_ins[k][63:32], nv} & m; wr_ir = 1; end
        12'hB82: begin m_ins[k] = {nv, m_ins[k][31:0]} & m; wr_ir = 1; end
        12'h320: new_inh = nv & 32'h5;
        default: ;
      endcase
    end
    if (!wr_cy && !m_inh[k][0])      m_cyc[k] = (m_cyc[k] + 64'd1) & m;
    if (!wr_ir && ir && !m_inh[k][2]) m_ins[k] = (m_ins[k] + 64'd1) & m;
    if (tick) begin m_tim[k] = (m_tim[k] + 64'd1) & m; m_pre[k] = 0; end
    else      m_pre[k] = m_pre[k] + 1;
    m_inh[k] = new_inh;
  endtask

  always @(posedge clk) begin
    if (!reset_ni) model_reset();
    else begin
      model_step(0);
      model_step(1);
    end
  end

  task automatic cmp(input string name, input logic [32:0] act, input logic [32:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got rdata=%h illegal=%b, expected rdata=%h illegal=%b",
               name, act[32:1], act[0], exp[32:1], exp[0]);
    end
  endtask

  always @(negedge clk) if (mon_on) begin
    if (a_vld) begin
      if (exp_a.size() == 0) cmp("A_unexpected_rsp", {a_dat, a_ill}, 33'h1_FFFF_FFFF);
      else cmp("A_rsp", {a_dat, a_ill}, exp_a.pop_front());
    end else begin
      cmp("A_idle_outputs", {a_dat, a_ill}, 33'h0);
      if (exp_a.size() != 0) cmp("A_missing_rsp", 33'h0, exp_a.pop_front() | 33'h1);
    end
  end

  always @(negedge clk) if (mon_on) begin
    if (b_vld) begin
      if (exp_b.size() == 0) cmp("B_unexpected_rsp", {b_dat, b_ill}, 33'h1_FFFF_FFFF);
      else cmp("B_rsp", {b_dat, b_ill}, exp_b.pop_front());
    end else begin
      cmp("B_idle_outputs", {b_dat, b_ill}, 33'h0);
      if (exp_b.size() != 0) cmp("B_missing_rsp", 33'h0, exp_b.pop_front() | 33'h1);
    end
  end

  task automatic drv(input bit v, input logic [2:0] f, input logic [11:0] a,
                     input logic [31:0] d, input bit z, input bit r);
    @(negedge clk);
    csr_valid = v; f3 = f; addr = a; wd = d; srcz = z; ir = r;
  endtask

  task automatic idle(input int n, input bit r = 0);
    repeat (n) drv(0, 3'b000, 12'h000, 32'h0, 1'b0, r);
  endtask

  task automatic rd(input logic [11:0] a);
    drv(1, 3'b010, a, 32'h0, 1'b1, 0);
  endtask

  logic [11:0] addr_tbl[12] = '{12'hC00, 12'hC01, 12'hC02, 12'hC80, 12'hC81, 12'hC82,
                                12'hB00, 12'hB02, 12'hB80, 12'hB82, 12'h320, 12'h123};

  initial begin
    reset_ni = 1'b0; csr_valid = 1'b0; f3 = '0; addr = '0; wd = '0; srcz = 1'b0; ir = 1'b0;
    @(posedge clk);
    #1 mon_on = 1'b1;
    rd(12'hC00);                 // sampled while reset is low: must be discarded
    idle(1);
    reset_ni = 1'b1;
    // 10 counting edges precede the sampling edge of the read, so C00 returns 10.
    idle(9);
    rd(12'hC00);
    rd(12'hC01);                 // prescaled time

    // Wrap: all-ones then one counting edge back to zero.
    drv(1, 3'b001, 12'hB00, 32'hFFFF_FFFF, 1'b0, 0);
    drv(1, 3'b001, 12'hB80, 32'hFFFF_FFFF, 1'b0, 0);
    idle(1);
    rd(12'hC00);
    rd(12'hC80);

    // Inhibit cycle and instret, retire while frozen, then release.
    drv(1, 3'b001, 12'h320, 32'h5, 1'b0, 0);
    idle(3, 1);
    rd(12'hC00); rd(12'hC00); rd(12'hC02);
    drv(1, 3'b001, 12'h320, 32'h0, 1'b0, 0);
    idle(2, 1);
    rd(12'hC02);

    // Write beats a same-cycle retire; C-range writes are rejected.
    drv(1, 3'b001, 12'hB02, 32'h7, 1'b0, 1);
    rd(12'hB02);
    drv(1, 3'b001, 12'hC00, 32'h5, 1'b0, 0);
    rd(12'hC00);
    drv(1, 3'b011, 12'hC02, 32'h0, 1'b1, 0);    // RC with zero source is a read

    // Back-to-back immediate set/clear of mcountinhibit.CY.
    drv(1, 3'b110, 12'h320, 32'h1, 1'b0, 0);
    drv(1, 3'b111, 12'h320, 32'h1, 1'b0, 0);
    rd(12'h320);
    rd(12'hC80);

    // Illegal funct3 / unmapped address / high-word write with masked bits.
    drv(1, 3'b000, 12'hC00, 32'h0, 1'b1, 0);
    drv(1, 3'b100, 12'hB00, 32'h0, 1'b1, 0);
    drv(1, 3'b010, 12'h123, 32'h0, 1'b1, 0);
    drv(1, 3'b101, 12'hB82, 32'hFFFF_FF12, 1'b0, 0);
    rd(12'hC82);
    drv(1, 3'b001, 12'h320, 32'hFFFF_FFFF, 1'b0, 0);
    rd(12'h320);

    for (int i = 0; i < 600; i++) begin
      bit rst_pulse = ($urandom_range(0, 99) == 0);
      logic [31:0] d = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFF : $urandom;
      drv($urandom_range(0, 3) != 0, 3'($urandom_range(0, 7)),
          addr_tbl[$urandom_range(0, 11)], d, $urandom_range(0, 1) == 1,
          $urandom_range(0, 1) == 1);
      reset_ni = !rst_pulse;
    end
    reset_ni = 1'b1;
    idle(3);
    cmp("A_queue_drained", 33'(exp_a.size()), 33'h0);
    cmp("B_queue_drained", 33'(exp_b.size()), 33'h0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
